// File: rtl/test_sequencer_if.sv
// Event and status bundle shared by the keypad/game datapath, the test sequencer and the display mux.
interface test_sequencer_if;
    logic        sec_tick;
    logic        start_req;
    logic        abort;
    logic [13:0] target_words;
    logic        word_done;
    logic        key_miss;
    logic [2:0]  phase;
    logic [3:0]  countdown_val;
    logic        test_active;
    logic [15:0] elapsed_s;
    logic [13:0] words_done;
    logic [15:0] missed_cnt;
    logic [13:0] wpm;
    logic        wpm_valid;
    logic        result_page;

    modport slave (
        input  sec_tick, start_req, abort, target_words, word_done, key_miss,
        output phase, countdown_val, test_active, elapsed_s, words_done,
               missed_cnt, wpm, wpm_valid, result_page
    );

    modport master (
        output sec_tick, start_req, abort, target_words, word_done, key_miss,
        input  phase, countdown_val, test_active, elapsed_s, words_done,
               missed_cnt, wpm, wpm_valid, result_page
    );
endinterface

// File: rtl/test_sequencer.sv
// Typing-test run-phase controller: countdown, timed run, restoring-divide WPM calculation and paged result display.
module test_sequencer #(
    parameter int unsigned COUNTDOWN_S   = 3,
    parameter int unsigned TIME_LIMIT_S  = 0,
    parameter int unsigned RESULT_PAGE_S = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    test_sequencer_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_COUNTDOWN = 3'd1,
        S_RUN       = 3'd2,
        S_CALC      = 3'd3,
        S_RESULT    = 3'd4
    } state_e;

    localparam logic [3:0]  CD_INIT   = 4'(COUNTDOWN_S);
    localparam logic [15:0] TLIMIT    = 16'(TIME_LIMIT_S);
    localparam logic        HAS_LIMIT = (TIME_LIMIT_S != 0);
    localparam logic [15:0] PAGE_LAST = 16'(RESULT_PAGE_S - 1);
    localparam logic [13:0] WPM_MAX   = 14'd9999;
    localparam logic [4:0]  CALC_LAST = 5'd20;

    state_e      state_q, state_d;
    logic [3:0]  cd_q, cd_d;
    logic [15:0] elapsed_q, elapsed_d;
    logic [13:0] words_q, words_d;
    logic [15:0] miss_q, miss_d;
    logic [13:0] wpm_q, wpm_d;
    logic        wpm_vld_q, wpm_vld_d;
    logic        page_q, page_d;
    logic [15:0] page_cnt_q, page_cnt_d;
    logic [13:0] target_q, target_d;
    logic [4:0]  calc_cnt_q, calc_cnt_d;

    logic [19:0] quo_q, quo_d;
    logic [15:0] rem_q, rem_d;
    logic [15:0] dvs_q, dvs_d;
    logic [16:0] rem_sh;
    logic        rem_ge;
    logic [15:0] rem_nx;
    logic [19:0] quo_nx;
    logic        start_ok;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v, input logic en);
        if (en && (v != 16'hFFFF)) return v + 16'd1;
        return v;
    endfunction

    function automatic logic [13:0] sat_inc14(input logic [13:0] v, input logic en);
        if (en && (v != 14'h3FFF)) return v + 14'd1;
        return v;
    endfunction

    function automatic logic [13:0] clamp_wpm(input logic [19:0] q, input logic [15:0] dvs);
        if ((dvs == 16'd0) || (q > 20'(WPM_MAX))) return WPM_MAX;
        return q[13:0];
    endfunction

    // One restoring-divide iteration: numerator bits shift out of quo into rem, quotient bits shift in.
    assign rem_sh = {rem_q, quo_q[19]};
    assign rem_ge = (rem_sh >= {1'b0, dvs_q});
    assign rem_nx = rem_ge ? (rem_sh[15:0] - dvs_q) : rem_sh[15:0];
    assign quo_nx = {quo_q[18:0], rem_ge};
    assign start_ok = bus.start_req && (bus.target_words != 14'd0);

    always_comb begin
        state_d    = state_q;
        cd_d       = cd_q;
        elapsed_d  = elapsed_q;
        words_d    = words_q;
        miss_d     = miss_q;
        wpm_d      = wpm_q;
        wpm_vld_d  = wpm_vld_q;
        page_d     = page_q;
        page_cnt_d = page_cnt_q;
        target_d   = target_q;
        calc_cnt_d = calc_cnt_q;
        quo_d      = quo_q;
        rem_d      = rem_q;
        dvs_d      = dvs_q;

        if (bus.abort) begin
            state_d    = S_IDLE;
            cd_d       = 4'd0;
            elapsed_d  = 16'd0;
            words_d    = 14'd0;
            miss_d     = 16'd0;
            wpm_d      = 14'd0;
            wpm_vld_d  = 1'b0;
            page_d     = 1'b0;
            page_cnt_d = 16'd0;
            calc_cnt_d = 5'd0;
        end else begin
            case (state_q)
                S_IDLE, S_RESULT: begin
                    if (start_ok) begin
                        target_d   = bus.target_words;
                        elapsed_d  = 16'd0;
                        words_d    = 14'd0;
                        miss_d     = 16'd0;
                        wpm_vld_d  = 1'b0;
                        page_d     = 1'b0;
                        page_cnt_d = 16'd0;
                        cd_d       = CD_INIT;
                        state_d    = (CD_INIT == 4'd0) ? S_RUN : S_COUNTDOWN;
                    end else if ((state_q == S_RESULT) && bus.sec_tick) begin
                        if (page_cnt_q == PAGE_LAST) begin
                            page_d     = ~page_q;
                            page_cnt_d = 16'd0;
                        end else begin
                            page_cnt_d = page_cnt_q + 16'd1;
                        end
                    end
                end
                S_COUNTDOWN: begin
                    if (bus.sec_tick) begin
                        cd_d = cd_q - 4'd1;
                        if (cd_q <= 4'd1) begin
                            cd_d    = 4'd0;
                            state_d = S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    elapsed_d = sat_inc16(elapsed_q, bus.sec_tick);
                    words_d   = sat_inc14(words_q, bus.word_done);
                    miss_d    = sat_inc16(miss_q, bus.key_miss);
                    if ((words_d == target_q) || (HAS_LIMIT && (elapsed_d == TLIMIT))) begin
                        state_d    = S_CALC;
                        calc_cnt_d = 5'd0;
                    end
                end
                S_CALC: begin
                    calc_cnt_d = calc_cnt_q + 5'd1;
                    if (calc_cnt_q == 5'd0) begin
                        quo_d = 20'(words_q) * 20'd60;
                        rem_d = 16'd0;
                        dvs_d = elapsed_q;
                    end else begin
                        quo_d = quo_nx;
                        rem_d = rem_nx;
                        if (calc_cnt_q == CALC_LAST) begin
                            wpm_d      = clamp_wpm(quo_nx, dvs_q);
                            wpm_vld_d  = 1'b1;
                            page_d     = 1'b0;
                            page_cnt_d = 16'd0;
                            calc_cnt_d = 5'd0;
                            state_d    = S_RESULT;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cd_q       <= 4'd0;
            elapsed_q  <= 16'd0;
            words_q    <= 14'd0;
            miss_q     <= 16'd0;
            wpm_q      <= 14'd0;
            wpm_vld_q  <= 1'b0;
            page_q     <= 1'b0;
            page_cnt_q <= 16'd0;
            target_q   <= 14'd0;
            calc_cnt_q <= 5'd0;
        end else begin
            state_q    <= state_d;
            cd_q       <= cd_d;
            elapsed_q  <= elapsed_d;
            words_q    <= words_d;
            miss_q     <= miss_d;
            wpm_q      <= wpm_d;
            wpm_vld_q  <= wpm_vld_d;
            page_q     <= page_d;
            page_cnt_q <= page_cnt_d;
            target_q   <= target_d;
            calc_cnt_q <= calc_cnt_d;
        end
    end

    // Divider working registers are always loaded before use, so they carry no reset.
    always_ff @(posedge clk) begin
        quo_q <= quo_d;
        rem_q <= rem_d;
        dvs_q <= dvs_d;
    end

    assign bus.phase         = state_q;
    assign bus.countdown_val = cd_q;
    assign bus.test_active   = (state_q == S_RUN);
    assign bus.elapsed_s     = elapsed_q;
    assign bus.words_done    = words_q;
    assign bus.missed_cnt    = miss_q;
    assign bus.wpm           = wpm_q;
    assign bus.wpm_valid     = wpm_vld_q;
    assign bus.result_page   = page_q;
endmodule
